rvv_rt_xrf_wb_buffer: RTL and testbench

- Parametrised retire-to-XRF writeback buffer between the RVV ROB retire stage and the RVS scalar register file write ports.
- Accepts up to NUM_RT scalar-result uops per cycle over valid/ready and queues them in retire order.
- Drains up to NUM_WP entries per cycle to XRF write ports; a same-cycle WAW hazard stall preserves architectural write order.
- Successor to the fixed NUM_RT_UOP XRF writeback channel; adds buffering depth, an independent write-port count and x0 filtering.

---
 rtl/rvv_rt_xrf_wb_buffer_if.sv | 15 +
 rtl/rvv_rt_xrf_wb_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_rvv_rt_xrf_wb_buffer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rvv_rt_xrf_wb_buffer_if.sv
// Valid/ready bundle of N channels of {addr, data}. It is used on the retire side
// (N = NUM_RT) and on the XRF write-port side (N = NUM_WP).
interface rvv_rt_xrf_wb_buffer_if #(
   parameter int unsigned N    = 4,
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 5
);
   logic [N-1:0]      valid;
   logic [N*AW-1:0]   addr;
   logic [N*XLEN-1:0] data;
   logic [N-1:0]      ready;

   modport master (output valid, output addr, output data, input ready);
   modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/rvv_rt_xrf_wb_buffer.sv
// Retire-to-XRF writeback buffer: in-order queue with x0 filtering and a same-cycle WAW stall.
// Optional statistics outputs are enabled by defining RVV_RT_XRF_BUF_STATS_EN.

// Protocol checker for the buffer, instantiated by the top.
module rvv_rt_xrf_wb_buffer_chk #(
   parameter int unsigned NUM_RT = 4,
   parameter int unsigned NUM_WP = 2,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned CW     = 4
) (
   input logic              clk,
   input logic              rst,
   input logic [NUM_RT-1:0] rt_valid,
   input logic [NUM_WP-1:0] wp_ready,
   input logic [CW-1:0]     count
);
   a_rt_valid_prefix: assert property (@(posedge clk) disable iff (rst)
      ((rt_valid & (rt_valid + NUM_RT'(1))) == '0))
      else $error("rt_xrf_valid is not prefix-shaped: %b", rt_valid);

   a_wp_ready_prefix: assert property (@(posedge clk) disable iff (rst)
      ((wp_ready & (wp_ready + NUM_WP'(1))) == '0))
      else $error("wp_ready is not prefix-shaped: %b", wp_ready);

   a_count_bound: assert property (@(posedge clk) disable iff (rst)
      (count <= CW'(DEPTH)))
      else $error("buffer count %0d exceeds DEPTH", count);
endmodule

module rvv_rt_xrf_wb_buffer #(
   parameter int unsigned NUM_RT = 4,
   parameter int unsigned NUM_WP = 2,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned XLEN   = 32,
   parameter int unsigned AW     = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   rvv_rt_xrf_wb_buffer_if.slave  rt_xrf,
   rvv_rt_xrf_wb_buffer_if.master wp,
   output logic                   buf_empty,
   output logic                   buf_full
`ifdef RVV_RT_XRF_BUF_STATS_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] stat_max_occ,
   output logic [31:0]                stat_full_stall
`endif
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   // Circular increment for any DEPTH; n never exceeds DEPTH, so one subtraction suffices.
   function automatic ptr_t ptr_add(input ptr_t p, input int unsigned n);
      int unsigned s;
      s = 32'(p) + n;
      s = (s >= DEPTH) ? (s - DEPTH) : s;
      return ptr_t'(s);
   endfunction

   logic [AW-1:0]   mem_addr_q [DEPTH];
   logic [AW-1:0]   mem_addr_d [DEPTH];
   logic [XLEN-1:0] mem_data_q [DEPTH];
   logic [XLEN-1:0] mem_data_d [DEPTH];

   ptr_t rd_ptr_q, rd_ptr_d;
   ptr_t wr_ptr_q, wr_ptr_d;
   cnt_t count_q, count_d;
   cnt_t space_d;
   cnt_t push_s, pop_s;

   logic [NUM_RT-1:0]      rt_ready_q, rt_ready_d;
   logic                   empty_q, empty_d;
   logic                   full_q, full_d;
   logic [NUM_WP-1:0]      wp_valid_s;
   logic [NUM_WP*AW-1:0]   wp_addr_s;
   logic [NUM_WP*XLEN-1:0] wp_data_s;
   logic [AW-1:0]          cand_addr_s [NUM_WP];

   // Enqueue: store accepted non-x0 channels contiguously from wr_ptr in channel order.
   always_comb begin
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      wr_ptr_d   = wr_ptr_q;
      push_s     = '0;
      for (int unsigned i = 0; i < NUM_RT; i++) begin
         logic store;
         store = rt_xrf.valid[i] & rt_ready_q[i] & (rt_xrf.addr[i*AW +: AW] != '0);
         if (store) begin
            mem_addr_d[wr_ptr_d] = rt_xrf.addr[i*AW +: AW];
            mem_data_d[wr_ptr_d] = rt_xrf.data[i*XLEN +: XLEN];
            wr_ptr_d             = ptr_add(wr_ptr_d, 32'd1);
            push_s               = push_s + cnt_t'(1);
         end else begin
            push_s = push_s;
         end
      end
   end

   // Dequeue candidates; a repeated rd suppresses that slot and every slot above it.
   always_comb begin
      logic stall;
      stall      = 1'b0;
      wp_valid_s = '0;
      wp_addr_s  = '0;
      wp_data_s  = '0;
      for (int unsigned j = 0; j < NUM_WP; j++) begin
         ptr_t cp;
         cp                          = ptr_add(rd_ptr_q, j);
         cand_addr_s[j]              = mem_addr_q[cp];
         wp_addr_s[j*AW +: AW]       = mem_addr_q[cp];
         wp_data_s[j*XLEN +: XLEN]   = mem_data_q[cp];
         for (int unsigned k = 0; k < j; k++) begin
            stall = stall | (cand_addr_s[k] == cand_addr_s[j]);
         end
         wp_valid_s[j] = (cnt_t'(j) < count_q) & ~stall;
      end
   end

   // Pop is the leading run of accepted write ports; derive next pointers, count and flags.
   always_comb begin
      logic run;
      run   = 1'b1;
      pop_s = '0;
      for (int unsigned j = 0; j < NUM_WP; j++) begin
         run   = run & wp_valid_s[j] & wp.ready[j];
         pop_s = pop_s + (run ? cnt_t'(1) : cnt_t'(0));
      end
      rd_ptr_d = ptr_add(rd_ptr_q, 32'(pop_s));
      count_d  = count_q + push_s - pop_s;
      space_d  = cnt_t'(DEPTH) - count_d;
      for (int unsigned i = 0; i < NUM_RT; i++) begin
         rt_ready_d[i] = (space_d > cnt_t'(i));
      end
      empty_d = (count_d == '0);
      full_d  = (count_d == cnt_t'(DEPTH));
   end

   // Control state; ready and the flags are registered images of the registered count.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         rt_ready_q <= '1;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         rt_ready_q <= rt_ready_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
      end
   end

   // Entry storage is deliberately left unreset; nothing is written during reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
      end
   end

   assign rt_xrf.ready = rt_ready_q;
   assign wp.valid     = wp_valid_s;
   assign wp.addr      = wp_addr_s;
   assign wp.data      = wp_data_s;
   assign buf_empty    = empty_q;
   assign buf_full     = full_q;

`ifdef RVV_RT_XRF_BUF_STATS_EN
   cnt_t        max_occ_q, max_occ_d;
   logic [31:0] full_stall_q, full_stall_d;

   // Occupancy high-watermark and saturating count of retire cycles blocked by a full buffer.
   always_comb begin
      max_occ_d    = (count_d > max_occ_q) ? count_d : max_occ_q;
      full_stall_d = (full_q && rt_xrf.valid[0] && (full_stall_q != '1)) ?
                     (full_stall_q + 32'd1) : full_stall_q;
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         max_occ_q    <= '0;
         full_stall_q <= '0;
      end else begin
         max_occ_q    <= max_occ_d;
         full_stall_q <= full_stall_d;
      end
   end

   assign stat_max_occ    = max_occ_q;
   assign stat_full_stall = full_stall_q;
`endif

   rvv_rt_xrf_wb_buffer_chk #(
      .NUM_RT (NUM_RT),
      .NUM_WP (NUM_WP),
      .DEPTH  (DEPTH),
      .CW     (CW)
   ) u_chk (
      .clk      (clk),
      .rst      (rst),
      .rt_valid (rt_xrf.valid),
      .wp_ready (wp.ready),
      .count    (count_q)
   );
endmodule

// File: tb/tb_rvv_rt_xrf_wb_buffer.sv
// Scoreboard bench for rvv_rt_xrf_wb_buffer with a non-power-of-2 DEPTH to exercise pointer wrap.
module tb_rvv_rt_xrf_wb_buffer;
   localparam int unsigned NUM_RT = 4;
   localparam int unsigned NUM_WP = 2;
   localparam int unsigned DEPTH  = 6;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned AW     = 5;
   localparam int unsigned CW     = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   logic buf_empty;
   logic buf_full;
`ifdef RVV_RT_XRF_BUF_STATS_EN
   logic [CW-1:0] stat_max_occ;
   logic [31:0]   stat_full_stall;
`endif

   rvv_rt_xrf_wb_buffer_if #(.N(NUM_RT), .XLEN(XLEN), .AW(AW)) rt_if ();
   rvv_rt_xrf_wb_buffer_if #(.N(NUM_WP), .XLEN(XLEN), .AW(AW)) wp_if ();

   rvv_rt_xrf_wb_buffer #(
      .NUM_RT (NUM_RT),
      .NUM_WP (NUM_WP),
      .DEPTH  (DEPTH),
      .XLEN   (XLEN),
      .AW     (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rt_xrf    (rt_if),
      .wp        (wp_if),
      .buf_empty (buf_empty),
      .buf_full  (buf_full)
`ifdef RVV_RT_XRF_BUF_STATS_EN
      ,
      .stat_max_occ    (stat_max_occ),
      .stat_full_stall (stat_full_stall)
`endif
   );

   always #5 clk = ~clk;

   ent_t sb[$];
   int   n_tests     = 0;
   int   n_fail      = 0;
   int   exp_max_occ = 0;
   int   exp_stall   = 0;
   int   seq         = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, check outputs at the falling edge, update the scoreboard.
   task automatic cycle(input logic [NUM_RT-1:0] v, input logic [NUM_RT*AW-1:0] av,
                        input logic [NUM_RT*XLEN-1:0] dv, input logic [NUM_WP-1:0] wr);
      logic [NUM_RT-1:0] er;
      logic [NUM_WP-1:0] ev;
      bit   stall;
      int   pop;
      int   space;
      ent_t e;
      rt_if.valid = v;
      rt_if.addr  = av;
      rt_if.data  = dv;
      wp_if.ready = wr;
      @(negedge clk);
      space = DEPTH - sb.size();
      for (int i = 0; i < NUM_RT; i++) er[i] = (space > i);
      check_eq("rt_ready", 64'(rt_if.ready), 64'(er));
      check_eq("buf_empty", 64'(buf_empty), 64'(sb.size() == 0));
      check_eq("buf_full", 64'(buf_full), 64'(sb.size() == DEPTH));
      if (sb.size() == DEPTH && v[0]) exp_stall++;
      stall = 1'b0;
      ev    = '0;
      for (int j = 0; j < NUM_WP; j++) begin
         if (j < sb.size()) begin
            for (int k = 0; k < j; k++) if (sb[k].addr == sb[j].addr) stall = 1'b1;
            ev[j] = !stall;
         end
      end
      check_eq("wp_valid", 64'(wp_if.valid), 64'(ev));
      pop = 0;
      for (int j = 0; j < NUM_WP; j++) if (ev[j] && wr[j] && pop == j) pop++;
      for (int j = 0; j < pop; j++) begin
         e = sb.pop_front();
         check_eq("wp_addr", 64'(wp_if.addr[j*AW +: AW]), 64'(e.addr));
         check_eq("wp_data", 64'(wp_if.data[j*XLEN +: XLEN]), 64'(e.data));
      end
      for (int i = 0; i < NUM_RT; i++) begin
         if (v[i] && er[i] && av[i*AW +: AW] != '0)
            sb.push_back({av[i*AW +: AW], dv[i*XLEN +: XLEN]});
      end
      if (sb.size() > exp_max_occ) exp_max_occ = sb.size();
      @(posedge clk);
      #1;
   endtask

   // Drive channels with a running sequence of distinct non-zero rd values.
   task automatic push_seq(input logic [NUM_RT-1:0] v, input logic [NUM_WP-1:0] wr);
      logic [NUM_RT*AW-1:0]   av;
      logic [NUM_RT*XLEN-1:0] dv;
      for (int i = 0; i < NUM_RT; i++) begin
         av[i*AW +: AW]     = AW'((seq % 31) + 1);
         dv[i*XLEN +: XLEN] = 32'hC0DE_0000 + 32'(seq);
         if (v[i]) seq++;
      end
      cycle(v, av, dv, wr);
   endtask

   task automatic drain();
      for (int t = 0; t < 20 && sb.size() > 0; t++) cycle('0, '0, '0, 2'b11);
      check_eq("drain_left", 64'(sb.size()), 64'd0);
      cycle('0, '0, '0, 2'b11);
   endtask

   task automatic check_stats();
`ifdef RVV_RT_XRF_BUF_STATS_EN
      check_eq("stat_max_occ", 64'(stat_max_occ), 64'(exp_max_occ));
      check_eq("stat_full_stall", 64'(stat_full_stall), 64'(exp_stall));
`endif
   endtask

   // Reset with retire traffic still offered; nothing may be stored in that cycle.
   task automatic do_reset();
      rst         = 1'b1;
      rt_if.valid = 4'b1111;
      rt_if.addr  = {5'd9, 5'd8, 5'd7, 5'd6};
      rt_if.data  = {32'h0BAD_0003, 32'h0BAD_0002, 32'h0BAD_0001, 32'h0BAD_0000};
      wp_if.ready = 2'b11;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      exp_max_occ = 0;
      exp_stall   = 0;
      check_stats();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NUM_RT-1:0]      v;
      logic [NUM_RT*AW-1:0]   av;
      logic [NUM_RT*XLEN-1:0] dv;
      rst         = 1'b1;
      rt_if.valid = '0;
      rt_if.addr  = '0;
      rt_if.data  = '0;
      wp_if.ready = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_stats();
      cycle('0, '0, '0, 2'b11);

      // Four retires, drained two per cycle.
      cycle(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},
            {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 2'b11);
      drain();
      check_stats();

      // x0 destination is handshaken but never written.
      cycle(4'b0011, {5'd0, 5'd0, 5'd5, 5'd0},
            {32'h0, 32'h0, 32'hEEEE_0005, 32'hDEAD_0000}, 2'b11);
      drain();

      // Two writes to the same rd must leave on separate cycles, in order.
      cycle(4'b0011, {5'd0, 5'd0, 5'd7, 5'd7},
            {32'h0, 32'h0, 32'h0000_0002, 32'h0000_0001}, 2'b11);
      drain();

      // Fill with the sink stalled, hold retire while full, then release.
      push_seq(4'b1111, 2'b00);
      push_seq(4'b1111, 2'b00);
      push_seq(4'b1111, 2'b00);
      cycle('0, '0, '0, 2'b11);
      drain();
      check_stats();

      // Sustained 3-in / 2-out traffic across many pointer wraps.
      for (int c = 0; c < 20; c++) push_seq(4'b0111, 2'b11);
      drain();

      // Random prefix-shaped traffic with a small rd set to hit x0 and WAW often.
      for (int c = 0; c < 60; c++) begin
         int nv;
         int nr;
         nv = $urandom_range(0, NUM_RT);
         nr = $urandom_range(0, NUM_WP);
         for (int i = 0; i < NUM_RT; i++) begin
            v[i]               = (i < nv);
            av[i*AW +: AW]     = AW'($urandom_range(0, 3));
            dv[i*XLEN +: XLEN] = $urandom;
         end
         cycle(v, av, dv, NUM_WP'((1 << nr) - 1));
      end
      drain();
      check_stats();

      // Reset with five entries queued.
      push_seq(4'b1111, 2'b00);
      push_seq(4'b0001, 2'b00);
      check_eq("pre_reset_count", 64'(sb.size()), 64'd5);
      do_reset();
      cycle('0, '0, '0, 2'b11);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
